// File: rtl/score_pkg.sv
// Shared types and constants for the score event scheduler.
// Point values are BCD; ghost points depend on the chain index.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD0,
        ADD1,
        ADD2,
        CHECK
    } state_t;

    localparam logic [1:0] SRC_DOT    = 2'd0;
    localparam logic [1:0] SRC_PELLET = 2'd1;
    localparam logic [1:0] SRC_GHOST  = 2'd2;
    localparam logic [1:0] SRC_FRUIT  = 2'd3;

    localparam logic [11:0] PTS_DOT    = 12'h001;
    localparam logic [11:0] PTS_PELLET = 12'h005;
    localparam logic [11:0] PTS_FRUIT  = 12'h050;
    localparam logic [11:0] PTS_GHOST0 = 12'h020;
    localparam logic [11:0] PTS_GHOST1 = 12'h040;
    localparam logic [11:0] PTS_GHOST2 = 12'h080;
    localparam logic [11:0] PTS_GHOST3 = 12'h160;

    function automatic logic [11:0] ghost_pts(input logic [1:0] idx);
        logic [11:0] p;
        case (idx)
            2'd0:    p = PTS_GHOST0;
            2'd1:    p = PTS_GHOST1;
            2'd2:    p = PTS_GHOST2;
            default: p = PTS_GHOST3;
        endcase
        return p;
    endfunction

    function automatic logic [11:0] src_pts(input logic [1:0] src,
                                            input logic [1:0] chain);
        logic [11:0] p;
        case (src)
            SRC_DOT:    p = PTS_DOT;
            SRC_PELLET: p = PTS_PELLET;
            SRC_GHOST:  p = ghost_pts(chain);
            default:    p = PTS_FRUIT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/score_event_scheduler_bcd_digit_add.sv
// Single BCD digit adder with carry in/out.
// Combinational; shared across the three add states.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        adj  = raw - 5'd10;
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > 5'd9) begin
            sum  = adj[3:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_event_scheduler.sv
// Queues collision scoring events per source and adds them
// round-robin into a serial 3-digit BCD score.
module score_event_scheduler
    import score_pkg::*;
#(
    parameter int          PEND_W      = 3,
    parameter logic [11:0] LIFE_THRESH = 12'h100
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear_score,
    input  logic        dot_hit,
    input  logic        pellet_hit,
    input  logic        ghost_hit,
    input  logic        fruit_hit,
    output logic [11:0] score,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        extra_life,
    output logic        overflow,
    output logic        dropped
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_t            state;
    logic [3:0]        hits;
    logic [3:0]        prev;
    logic [3:0]        rise;
    logic [PEND_W-1:0] pend [4];
    logic [3:0]        req;
    logic [3:0]        at_max;
    logic [1:0]        rr_ptr;
    logic [1:0]        chain;
    logic [1:0]        cand;
    logic [1:0]        pick_idx;
    logic              pick_vld;
    logic              arb_en;
    logic [3:0]        gnt_next;
    logic [11:0]       work;
    logic [11:0]       addend;
    logic              carry;
    logic              life_awarded;
    logic [3:0]        da;
    logic [3:0]        db;
    logic              dcin;
    logic [3:0]        dsum;
    logic              dcout;

    assign hits = {fruit_hit, ghost_hit, pellet_hit, dot_hit};
    assign rise = hits & ~prev;
    assign busy = (state != IDLE);

    // A grant is decided on the edge that enters IDLE, so the
    // registered grant is visible during the IDLE cycle itself.
    assign arb_en = ((state == IDLE) && (grant == 4'b0))
                  || (state == CHECK);

    always_comb begin
        req    = '0;
        at_max = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]    = (pend[i] != '0) | rise[i];
            at_max[i] = (pend[i] == PEND_MAX);
        end
    end

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign gnt_next = (arb_en && pick_vld) ? (4'b1 << pick_idx) : 4'b0;

    always_comb begin
        da   = 4'd0;
        db   = 4'd0;
        dcin = 1'b0;
        case (state)
            ADD0: begin
                da = score[3:0];
                db = addend[3:0];
            end
            ADD1: begin
                da   = score[7:4];
                db   = addend[7:4];
                dcin = carry;
            end
            ADD2: begin
                da   = score[11:8];
                db   = addend[11:8];
                dcin = carry;
            end
            default: ;
        endcase
    end

    bcd_digit_add u_add (
        .a    (da),
        .b    (db),
        .cin  (dcin),
        .sum  (dsum),
        .cout (dcout)
    );

    always_ff @(posedge clk) begin
        if (!resetN || clear_score) begin
            state        <= IDLE;
            prev         <= '0;
            rr_ptr       <= '0;
            chain        <= '0;
            work         <= '0;
            addend       <= '0;
            carry        <= 1'b0;
            life_awarded <= 1'b0;
            score        <= '0;
            grant        <= '0;
            extra_life   <= 1'b0;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
            for (int i = 0; i < 4; i++) pend[i] <= '0;
        end else begin
            prev       <= hits;
            grant      <= gnt_next;
            extra_life <= 1'b0;
            dropped    <= |(rise & ~gnt_next & at_max);

            for (int i = 0; i < 4; i++) begin
                if (rise[i] && !gnt_next[i] && !at_max[i])
                    pend[i] <= pend[i] + PEND_ONE;
                else if (!rise[i] && gnt_next[i])
                    pend[i] <= pend[i] - PEND_ONE;
            end

            if (gnt_next != 4'b0) begin
                rr_ptr <= pick_idx + 2'd1;
                addend <= src_pts(pick_idx, chain);
                if (pick_idx == SRC_GHOST && chain != 2'd3)
                    chain <= chain + 2'd1;
                else if (pick_idx == SRC_PELLET)
                    chain <= 2'd0;
            end

            case (state)
                IDLE: begin
                    if (grant != 4'b0) state <= ADD0;
                end
                ADD0: begin
                    work[3:0] <= dsum;
                    carry     <= dcout;
                    state     <= ADD1;
                end
                ADD1: begin
                    work[7:4] <= dsum;
                    carry     <= dcout;
                    state     <= ADD2;
                end
                ADD2: begin
                    carry <= dcout;
                    if (dcout) begin
                        work     <= 12'h999;
                        overflow <= 1'b1;
                    end else begin
                        work[11:8] <= dsum;
                    end
                    state <= CHECK;
                end
                CHECK: begin
                    score <= work;
                    if (score < LIFE_THRESH && work >= LIFE_THRESH
                        && !life_awarded) begin
                        extra_life   <= 1'b1;
                        life_awarded <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed and randomized checks of the score event scheduler
// against an integer-arithmetic scoring model.
module tb_score_event_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        clear_score;
    logic [3:0]  hits;
    logic [11:0] score;
    logic [3:0]  grant;
    logic        busy;
    logic        extra_life;
    logic        overflow;
    logic        dropped;

    int vectors     = 0;
    int miscompares = 0;

    int cyc       = 0;
    int life_cnt  = 0;
    int drop_cnt  = 0;
    logic [3:0] gq[$];
    int         gt[$];

    int mscore  = 0;
    int mchain  = 0;
    bit mlife   = 0;
    bit movf    = 0;
    int exp_life = 0;

    always #5 clk = ~clk;

    score_event_scheduler #(.PEND_W(3), .LIFE_THRESH(12'h100)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .clear_score (clear_score),
        .dot_hit     (hits[0]),
        .pellet_hit  (hits[1]),
        .ghost_hit   (hits[2]),
        .fruit_hit   (hits[3]),
        .score       (score),
        .grant       (grant),
        .busy        (busy),
        .extra_life  (extra_life),
        .overflow    (overflow),
        .dropped     (dropped)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (grant != 4'b0) begin
            gq.push_back(grant);
            gt.push_back(cyc);
        end
        if (extra_life) life_cnt <= life_cnt + 1;
        if (dropped) drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic model(input int src);
        int pts;
        int old;
        pts = 0;
        case (src)
            0: pts = 1;
            1: begin pts = 5; mchain = 0; end
            2: begin
                pts = (mchain == 0) ? 20 : (mchain == 1) ? 40
                    : (mchain == 2) ? 80 : 160;
                if (mchain < 3) mchain++;
            end
            default: pts = 50;
        endcase
        old = mscore;
        if (mscore + pts > 999) begin
            mscore = 999;
            movf   = 1;
        end else begin
            mscore = mscore + pts;
        end
        if (old < 100 && mscore >= 100 && !mlife) begin
            mlife = 1;
            exp_life++;
        end
    endtask

    task automatic model_clear();
        mscore = 0;
        mchain = 0;
        mlife  = 0;
        movf   = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [3:0] m);
        hits = m;
        step();
        hits = 4'b0;
    endtask

    task automatic settle();
        int idle = 0;
        int n = 0;
        while (idle < 2 && n < 2000) begin
            step();
            n++;
            if (!busy && grant == 4'b0) idle++;
            else idle = 0;
        end
        chk("settle_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic do_clear();
        clear_score = 1'b1;
        step();
        clear_score = 1'b0;
        model_clear();
        chk("clear_score", 32'(score), 32'h0);
    endtask

    task automatic ev(input int src);
        fire(4'b1 << src);
        model(src);
        settle();
        chk("ev_score", 32'(score), 32'(to_bcd(mscore)));
        chk("ev_ovf", 32'(overflow), 32'(movf));
    endtask

    initial begin
        resetN      = 1'b0;
        clear_score = 1'b0;
        hits        = 4'b0;
        repeat (3) step();
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_life", 32'(extra_life), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_drop", 32'(dropped), 32'h0);
        resetN = 1'b1;
        step();

        // single dot: grant next cycle, 4 busy cycles, score at t+6
        hits[0] = 1'b1;
        step();
        chk("dot_grant", 32'(grant), 32'h1);
        chk("dot_busy0", 32'(busy), 32'h0);
        hits[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("dot_busy", 32'(busy), 32'h1);
            chk("dot_grant_lo", 32'(grant), 32'h0);
            if (i == 4) chk("dot_no_partial", 32'(score), 32'h0);
        end
        step();
        chk("dot_busy_end", 32'(busy), 32'h0);
        model(0);
        chk("dot_score", 32'(score), 32'(to_bcd(mscore)));

        // all four sources at once from a fresh pointer
        do_clear();
        gq.delete();
        gt.delete();
        fire(4'hF);
        for (int s = 0; s < 4; s++) model(s);
        settle();
        chk("all4_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < gq.size(); i++) begin
            chk("all4_order", 32'(gq[i]), 32'(4'b1 << i));
            if (i > 0) chk("all4_space", 32'(gt[i] - gt[i-1]), 32'd5);
        end
        chk("all4_score", 32'(score), 32'h076);

        // ghost chain and its reset by a pellet
        do_clear();
        life_cnt = 0;
        exp_life = 0;
        ev(1);
        for (int i = 0; i < 4; i++) ev(2);
        chk("chain_score", 32'(score), 32'h305);
        ev(1);
        ev(2);
        chk("chain_reset", 32'(score), 32'h330);
        chk("chain_life", 32'(life_cnt), 32'(exp_life));

        // preload 98, pellet crosses the threshold once
        do_clear();
        life_cnt = 0;
        exp_life = 0;
        for (int i = 0; i < 98; i++) ev(0);
        chk("pre98", 32'(score), 32'h098);
        ev(1);
        chk("cross_score", 32'(score), 32'h103);
        chk("cross_life", 32'(life_cnt), 32'd1);
        ev(3);
        chk("no_second_life", 32'(life_cnt), 32'd1);

        // saturation at 999
        do_clear();
        for (int i = 0; i < 19; i++) ev(3);
        ev(2);
        for (int i = 0; i < 4; i++) ev(1);
        chk("pre990", 32'(score), 32'h990);
        ev(3);
        chk("sat_score", 32'(score), 32'h999);
        chk("sat_ovf", 32'(overflow), 32'h1);
        gq.delete();
        ev(0);
        chk("sat_grant", 32'(gq.size()), 32'd1);
        chk("sat_hold", 32'(score), 32'h999);

        // 13 back-to-back dot rises: queue of 7 fills, one drops
        do_clear();
        drop_cnt = 0;
        for (int k = 0; k < 13; k++) begin
            hits[0] = 1'b1;
            step();
            hits[0] = 1'b0;
            step();
        end
        settle();
        for (int k = 0; k < 12; k++) model(0);
        chk("drop_cnt", 32'(drop_cnt), 32'd1);
        chk("drop_score", 32'(score), 32'(to_bcd(mscore)));

        // clear while in ADD1 aborts the add and empties the queue
        do_clear();
        for (int k = 0; k < 6; k++) begin
            hits[0] = 1'b1;
            step();
            hits[0] = 1'b0;
            step();
        end
        begin
            int n = 0;
            while (grant == 4'b0 && n < 20) begin
                step();
                n++;
            end
            chk("abort_wait", 32'(n < 20), 32'd1);
        end
        step();
        step();
        clear_score = 1'b1;
        step();
        clear_score = 1'b0;
        model_clear();
        chk("abort_score", 32'(score), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_grant", 32'(grant), 32'h0);
        gq.delete();
        repeat (30) step();
        chk("abort_quiet", 32'(gq.size()), 32'd0);
        chk("abort_hold", 32'(score), 32'h0);

        // random event stream
        do_clear();
        life_cnt = 0;
        exp_life = 0;
        for (int i = 0; i < 40; i++) ev(int'($urandom_range(0, 3)));
        chk("rand_life", 32'(life_cnt), 32'(exp_life));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_event_scheduler.md
# score_event_scheduler

Collects scoring events from the game-logic collision detectors (dot, power pellet, ghost, fruit), queues them per source, and arbitrates them round-robin onto a single serial 3-digit BCD score accumulator. Sits between the collision/object logic and the VGA score display; owns the displayed score, the ghost-chain multiplier and the extra-life award.

## Interface
- `PEND_W`, 3: width of each per-source pending counter; max pending = 2^PEND_W−1.
- `LIFE_THRESH`, 12'h100: BCD score at which the single extra life is awarded.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset, synchronous, active-low.
- `clear_score`  in  1  synchronous new-game clear; lower priority than `resetN`.
- `dot_hit`  in  1  level input, source 0; one event per rising edge.
- `pellet_hit`  in  1  level input, source 1; one event per rising edge.
- `ghost_hit`  in  1  level input, source 2; one event per rising edge.
- `fruit_hit`  in  1  level input, source 3; one event per rising edge.
- `score`  out  12  BCD score; [3:0] ones, [7:4] tens, [11:8] hundreds.
- `grant`  out  4  one-hot; source whose event is accepted this cycle.
- `busy`  out  1  high while the FSM is not IDLE.
- `extra_life`  out  1  one-cycle pulse when the score first reaches ≥ `LIFE_THRESH`.
- `overflow`  out  1  sticky; score saturated at 999.
- `dropped`  out  1  one-cycle pulse when an edge arrives at a saturated pending counter.

## Operation
- Edge detect: previous-value register per input, reset 0; rise = in & ~prev.
- Pending counters: +1 on rise, −1 on grant; rise and grant in the same cycle leaves the count unchanged. A rise at max is discarded and pulses `dropped`.
- Arbitration, in IDLE only: round-robin over sources with pending ≠ 0, starting at `rr_ptr`. After a grant, `rr_ptr` = granted index + 1 mod 4. Reset `rr_ptr` = 0.
- Addend, BCD, latched at grant: dot 12'h001, pellet 12'h005, fruit 12'h050, ghost 12'h020 / 040 / 080 / 160 for chain index 0/1/2/≥3.
- Ghost chain: index increments on each ghost grant and saturates at 3. It resets to 0 on a pellet grant.
- FSM states are IDLE → ADD0 → ADD1 → ADD2 → CHECK → IDLE.
  - IDLE: grant if anything is pending; otherwise stay in IDLE.
  - ADD0, ADD1 and ADD2: work digit k = score digit k + addend digit k + carry. If the sum > 9, subtract 10 and set carry = 1. Carry into ADD0 is 0.
  - Carry out of ADD2 → the work register is forced to 12'h999 and `overflow` is set.
  - CHECK: commit the work register to `score`.
    - If old score < `LIFE_THRESH`, new score ≥ `LIFE_THRESH` and no life has been awarded yet → pulse `extra_life` and set `life_awarded`.
- Once `overflow` is set, further events are still granted; the score stays 999.
- `clear_score` clears the following:
  - score, work register, carry, chain, `overflow`, `life_awarded`, all pending counters, `rr_ptr` and edge-history registers.
  - It also forces the FSM to IDLE and aborts an in-flight add without committing it.
  - `grant` is 0 that cycle.
- Reset values: `score` 0, `grant` 0, `busy` 0, `extra_life` 0, `overflow` 0, `dropped` 0, FSM IDLE.

## Timing
- A rise sampled at edge t makes pending ≠ 0 from cycle t+1. The earliest grant is cycle t+1, registered `grant` high during t+1.
- Grant in cycle G: ADD0 G+1, ADD1 G+2, ADD2 G+3, CHECK G+4. `score` and `extra_life` change at the edge ending G+4 (visible G+5).
- The next grant is no earlier than G+5. Throughput is one event per 5 cycles.
- `busy` is high in cycles G+1..G+4.
- `score` never shows a partial (mid-add) value.
- A high-held input produces exactly one event.

## Structure
- Package `score_pkg` holds:
  - the `state_t` enum (IDLE, ADD0, ADD1, ADD2, CHECK);
  - source index constants `SRC_DOT`=0, `SRC_PELLET`=1, `SRC_GHOST`=2, `SRC_FRUIT`=3;
  - BCD point constants and the ghost chain table.
- Sub-module `bcd_digit_add`, combinational: 4-bit a, 4-bit b, carry-in → 4-bit digit, carry-out. It is instanced once and muxed by state.

## Test plan
- Single dot pulse from reset → `grant`=0001 in cycle t+1, `score`=12'h001 at t+6, `busy` high 4 cycles.
- Dot, pellet, ghost and fruit all rise in the same cycle → grants in order 0,1,2,3 at 5-cycle spacing; final `score`=12'h076.
- Pellet, then four ghost events → ghost adds of 20, 40, 80 and 160; `score`=12'h305.
  - Then another pellet and one ghost → ghost adds 20; `score`=12'h330.
- Preload score 12'h098 via 98 dot events, then a pellet → `score`=12'h103 and `extra_life` pulses exactly once. A later crossing into ≥ 100 gives no pulse.
- Score 12'h990 plus a fruit → `score`=12'h999 and `overflow`=1.
  - Then a dot → score stays 999 and `grant` still asserts.
- Eight dot rises while the FSM is busy with `PEND_W`=3 → seven queued and one `dropped` pulse.
  - `clear_score` asserted in ADD1 → `score`=0 and FSM IDLE next cycle, with no further grants.
